lcd_timing_gen: RTL
===================

Name: lcd_timing_gen

Overview:
- Parametrised RGB565 LCD timing and test-pattern generator; successor to the fixed-timing VGA driver.
- Timing (active/porch/sync per axis and sync polarity) is generic; default is the 1024x600 panel.
- Runs on the pixel clock and drives the LCD pins directly.
- Adds a selectable pattern mode, coordinate outputs, a frame-start pulse and a frame counter.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 160, horizontal front porch (clocks)
- H_SYNC, 20, HSYNC width (clocks)
- H_BP, 140, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines
- V_FP, 12, vertical front porch (lines)
- V_SYNC, 3, VSYNC width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 0, HSYNC active level (0 = active-low)
- VS_POL, 0, VSYNC active level (0 = active-low)
- X_W, 11, horizontal counter width; must be >= 10 and hold H_TOTAL-1
- Y_W, 10, vertical counter width; must be >= 10 and hold V_TOTAL-1
- CHECK_LOG2, 5, checkerboard square size is 2^CHECK_LOG2 pixels
- SOLID_RGB, 16'hF800, RGB565 colour for solid mode

Ports:
- CLK  in  1  pixel clock; the only clock
- nRST  in  1  asynchronous active-low reset
- MODE_IN  in  2  pattern select; sampled once per frame
- LCD_DE  out  1  data enable, active-high
- LCD_HSYNC  out  1  horizontal sync, polarity per HS_POL
- LCD_VSYNC  out  1  vertical sync, polarity per VS_POL
- LCD_R  out  5  red
- LCD_G  out  6  green
- LCD_B  out  5  blue
- PIX_X  out  X_W  horizontal position of the current output pixel
- PIX_Y  out  Y_W  vertical position of the current output pixel
- FRAME_START  out  1  one-cycle pulse aligned with pixel (0,0)
- FRAME_CNT  out  8  completed-frame counter, wraps at 256

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344); V_TOTAL likewise (default 635).
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it counts 0..V_TOTAL-1 and wraps to 0.
- Decode:
  - Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - HSYNC is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VSYNC uses the same rule on v_cnt.
- Latency:
  - All outputs are registered, one cycle after the counter state they describe.
  - DE, syncs, RGB, PIX_X/Y and FRAME_START are mutually cycle-aligned.
- PIX_X/PIX_Y equal the registered h_cnt/v_cnt, including during blanking.
- RGB is forced to 0 whenever LCD_DE is 0.
- Mode:
  - MODE_IN is latched into mode_q when h_cnt==0 and v_cnt==0, so it is applied from pixel (0,0) onward.
  - A mid-frame MODE_IN change is ignored until the next frame.
- Patterns (x, y = active coordinates):
  - 0, colour bars: bar index b = x / (H_ACTIVE>>3), implemented with a bar-width counter, no divider. Outputs: R = {5{~b[1]}}, G = {6{~b[2]}}, B = {5{~b[0]}}. Order is white, yellow, cyan, green, magenta, red, blue, black.
  - 1, gradient: R = x[9:5], G = x[9:4], B = y[9:5].
  - 2, checkerboard: white when x[CHECK_LOG2]^y[CHECK_LOG2] = 1, else black.
  - 3, solid: SOLID_RGB.
- FRAME_START:
  - High for exactly one cycle, concurrent with output pixel (0,0).
  - Also fires for the first frame after reset.
- FRAME_CNT increments on the cycle when the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0); it wraps 255 -> 0.
- Reset (asynchronous, at any time including mid-frame):
  - h_cnt, v_cnt, mode_q, FRAME_CNT, PIX_X, PIX_Y = 0.
  - LCD_DE = 0, RGB = 0, FRAME_START = 0.
  - Syncs at their inactive level (~HS_POL, ~VS_POL).
  - After release, the first clock edge loads counter (0,0) state, so the outputs restart a fresh frame cleanly.

Optional Feature:
- Macro: LCD_BORDER_EN.
- Defined: pixels with x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 output red (1F/00/00), overriding every mode. DE gating still applies.
- Undefined: no border logic; patterns are output unmodified.

Decomposition:
- Package lcd_pkg:
  - 2-bit mode enum (BARS, GRAD, CHECK, SOLID).
  - RGB565 struct {r[4:0], g[5:0], b[4:0]}.
  - Colour constants WHITE, BLACK, RED.
- Sub-module lcd_axis_counter, instantiated once per axis:
  - Parameters: ACTIVE, FP, SYNC, BP, W.
  - Inputs: advance enable.
  - Outputs: count, active, sync, wrap.

Test Plan:
- Default params, MODE_IN=0, run 2 frames -> LCD_DE high 1024 consecutive cycles per line, 600 lines per frame. HSYNC low 20 cycles every 1344; VSYNC low 3 lines every 635 lines.
- Colour bars -> pixel x=0: R/G/B = 1F/3F/1F. x=128: 1F/3F/00. x=896: 00/00/00. Blanking: RGB = 0.
- MODE_IN 0->3 at line 300 -> bars persist to the end of the frame; next frame at (0,0) outputs F800 on all active pixels.
- nRST pulse low at h=500, v=200 -> outputs immediately at reset values. After release: FRAME_START pulse together with PIX_X=0, PIX_Y=0, DE=1; FRAME_CNT=0.
- Run 257 frames -> FRAME_CNT sequence reaches 255, then 0, then 1; FRAME_START count equals 257.
- HS_POL=1, H_ACTIVE=64, V_ACTIVE=16, MODE_IN=2, CHECK_LOG2=2 -> HSYNC is active-high. Pixel (4,0) is white, (4,4) is black.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and colour constants for the LCD timing and test-pattern generator.
package lcd_pkg;

    typedef enum logic [1:0] {
        BARS  = 2'd0,
        GRAD  = 2'd1,
        CHECK = 2'd2,
        SOLID = 2'd3
    } mode_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb_t;

    localparam rgb_t WHITE = rgb_t'(16'hFFFF);
    localparam rgb_t BLACK = rgb_t'(16'h0000);
    localparam rgb_t RED   = rgb_t'(16'hF800);

    // Bar index bits map straight onto colour channels: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        c.r = {5{~idx[1]}};
        c.g = {6{~idx[2]}};
        c.b = {5{~idx[0]}};
        return c;
    endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// One timing axis: position counter with active-region and sync-window decode.
module lcd_axis_counter
    import lcd_pkg::*;
#(
    parameter int ACTIVE = 1024,
    parameter int FP     = 160,
    parameter int SYNC   = 20,
    parameter int BP     = 140,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic         active,
    output logic         sync,
    output logic         wrap
);

    localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC;

    assign wrap   = advance && (count == W'(TOTAL - 1));
    assign active = count < W'(ACTIVE);
    assign sync   = (count >= W'(SYNC_START)) && (count < W'(SYNC_END));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (advance) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB565 LCD timing and test-pattern generator with registered pin outputs.
// Optional build macro LCD_BORDER_EN draws a red one-pixel frame around the active area.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int          H_ACTIVE   = 1024,
    parameter int          H_FP       = 160,
    parameter int          H_SYNC     = 20,
    parameter int          H_BP       = 140,
    parameter int          V_ACTIVE   = 600,
    parameter int          V_FP       = 12,
    parameter int          V_SYNC     = 3,
    parameter int          V_BP       = 20,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int          X_W        = 11,
    parameter int          Y_W        = 10,
    parameter int          CHECK_LOG2 = 5,
    parameter logic [15:0] SOLID_RGB  = 16'hF800
) (
    input  logic           CLK,
    input  logic           nRST,
    input  logic [1:0]     MODE_IN,
    output logic           LCD_DE,
    output logic           LCD_HSYNC,
    output logic           LCD_VSYNC,
    output logic [4:0]     LCD_R,
    output logic [5:0]     LCD_G,
    output logic [4:0]     LCD_B,
    output logic [X_W-1:0] PIX_X,
    output logic [Y_W-1:0] PIX_Y,
    output logic           FRAME_START,
    output logic [7:0]     FRAME_CNT
);

    localparam int BAR_W = H_ACTIVE >> 3;

    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    logic           h_act, h_sync, h_wrap;
    logic           v_act, v_sync, v_wrap;

    lcd_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(X_W)
    ) u_h_axis (
        .clk(CLK), .rst_n(nRST), .advance(1'b1),
        .count(h_cnt), .active(h_act), .sync(h_sync), .wrap(h_wrap)
    );

    lcd_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(Y_W)
    ) u_v_axis (
        .clk(CLK), .rst_n(nRST), .advance(h_wrap),
        .count(v_cnt), .active(v_act), .sync(v_sync), .wrap(v_wrap)
    );

    // Bar index tracks h_cnt without a divider; it saturates at the last bar.
    logic [X_W-1:0] bar_px;
    logic [2:0]     bar_idx;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_wrap) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_act) begin
            if (bar_px == X_W'(BAR_W - 1)) begin
                bar_px <= '0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end

    // The frame's first pixel already uses the newly sampled mode.
    logic  frame_origin;
    mode_t mode_q;
    mode_t cur_mode;
    logic  de_next;
    rgb_t  pix;
    rgb_t  rgb_q;

    assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
    assign cur_mode     = frame_origin ? mode_t'(MODE_IN) : mode_q;
    assign de_next      = h_act && v_act;

    always_comb begin
        pix = BLACK;
        case (cur_mode)
            BARS:  pix = bar_colour(bar_idx);
            GRAD:  pix = '{r: h_cnt[9:5], g: h_cnt[9:4], b: v_cnt[9:5]};
            CHECK: pix = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? WHITE : BLACK;
            SOLID: pix = rgb_t'(SOLID_RGB);
            default: pix = BLACK;
        endcase
`ifdef LCD_BORDER_EN
        if (h_cnt == '0 || h_cnt == X_W'(H_ACTIVE - 1) ||
            v_cnt == '0 || v_cnt == Y_W'(V_ACTIVE - 1)) begin
            pix = RED;
        end
`endif
    end

    // Output register stage: everything describes the counter state of the previous cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            LCD_DE      <= 1'b0;
            LCD_HSYNC   <= ~HS_POL;
            LCD_VSYNC   <= ~VS_POL;
            rgb_q       <= BLACK;
            PIX_X       <= '0;
            PIX_Y       <= '0;
            FRAME_START <= 1'b0;
            FRAME_CNT   <= '0;
            mode_q      <= BARS;
        end else begin
            LCD_DE      <= de_next;
            LCD_HSYNC   <= h_sync ? HS_POL : ~HS_POL;
            LCD_VSYNC   <= v_sync ? VS_POL : ~VS_POL;
            rgb_q       <= de_next ? pix : BLACK;
            PIX_X       <= h_cnt;
            PIX_Y       <= v_cnt;
            FRAME_START <= frame_origin;
            if (v_wrap) FRAME_CNT <= FRAME_CNT + 8'd1;
            if (frame_origin) mode_q <= mode_t'(MODE_IN);
        end
    end

    assign LCD_R = rgb_q.r;
    assign LCD_G = rgb_q.g;
    assign LCD_B = rgb_q.b;

endmodule
